// File: rtl/debounce_pkg.sv
// Shared types for the debounce filter.
package debounce_pkg;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/sync.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync #(
    parameter int   STAGES     = 2,
    parameter logic ResetValue = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ff_q <= {STAGES{ResetValue}};
        else         ff_q <= {ff_q[STAGES-2:0], d};
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/sync_debounce.sv
// Synchronize an asynchronous level, then accept a new level only after it has
// been seen on Teff consecutive samples; rejected transitions are counted.
module sync_debounce
    import debounce_pkg::*;
#(
    parameter int   STAGES         = 2,
    parameter int   CntWidth       = 8,
    parameter int   GlitchCntWidth = 8,
    parameter logic ResetValue     = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      serial_i,
    input  logic                      en_i,
    input  logic [CntWidth-1:0]       thresh_i,
    input  logic                      clr_glitch_i,
    output logic                      level_o,
    output logic                      rise_o,
    output logic                      fall_o,
    output logic [GlitchCntWidth-1:0] glitch_cnt_o
);

    logic                      rst_n;
    logic                      s;
    logic [CntWidth-1:0]       teff;
    logic [CntWidth:0]         cnt_inc;
    db_state_e                 state_q, state_d;
    logic [CntWidth-1:0]       cnt_q, cnt_d;
    logic                      level_q, level_d;
    logic                      rise_q, fall_q;
    logic                      glitch_ev;
    logic [GlitchCntWidth-1:0] glitch_q, glitch_d;

    assign rst_n = ~rst_i;

    sync #(
        .STAGES    (STAGES),
        .ResetValue(ResetValue)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_n),
        .d     (serial_i),
        .q     (s)
    );

    // A zero threshold behaves like one: the filter never stalls.
    assign teff    = (thresh_i == '0) ? CntWidth'(1) : thresh_i;
    // One extra bit so the comparison cannot wrap at all-ones.
    assign cnt_inc = {1'b0, cnt_q} + (CntWidth + 1)'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        glitch_ev = 1'b0;
        if (!en_i) begin
            state_d = STABLE;
            cnt_d   = '0;
            level_d = s;
        end else begin
            case (state_q)
                STABLE: begin
                    if (s != level_q) begin
                        if (teff == CntWidth'(1)) begin
                            level_d = ~level_q;
                        end else begin
                            state_d = PENDING;
                            cnt_d   = CntWidth'(1);
                        end
                    end
                end
                PENDING: begin
                    if (s == level_q) begin
                        state_d   = STABLE;
                        cnt_d     = '0;
                        glitch_ev = 1'b1;
                    end else if (cnt_inc >= {1'b0, teff}) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                        level_d = ~level_q;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Clear wins over a simultaneous glitch.
    always_comb begin
        glitch_d = glitch_q;
        if (clr_glitch_i)                     glitch_d = '0;
        else if (glitch_ev && glitch_q != '1) glitch_d = glitch_q + GlitchCntWidth'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            level_q  <= ResetValue;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            rise_q   <= level_d & ~level_q;
            fall_q   <= ~level_d & level_q;
            glitch_q <= glitch_d;
        end
    end

    assign level_o      = level_q;
    assign rise_o       = rise_q;
    assign fall_o       = fall_q;
    assign glitch_cnt_o = glitch_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: directed vector table, hand sequences for the
// multi-cycle corners, and random stimulus against a run-length reference model.
module tb_sync_debounce;

    localparam int STAGES = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       serial = 1'b0;
    logic       en = 1'b1;
    logic [7:0] thresh = 8'd4;
    logic       clr = 1'b0;
    logic       level, rise, fall;
    logic [7:0] g8;
    logic       l2, r2, f2;
    logic [1:0] g2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_debounce #(.STAGES(STAGES), .CntWidth(8), .GlitchCntWidth(8), .ResetValue(1'b0)) dut (
        .clk_i(clk), .rst_i(rst), .serial_i(serial), .en_i(en), .thresh_i(thresh),
        .clr_glitch_i(clr), .level_o(level), .rise_o(rise), .fall_o(fall), .glitch_cnt_o(g8)
    );

    sync_debounce #(.STAGES(STAGES), .CntWidth(8), .GlitchCntWidth(2), .ResetValue(1'b0)) dut_g2 (
        .clk_i(clk), .rst_i(rst), .serial_i(serial), .en_i(en), .thresh_i(thresh),
        .clr_glitch_i(clr), .level_o(l2), .rise_o(r2), .fall_o(f2), .glitch_cnt_o(g2)
    );

    // Reference: s is the input seen STAGES edges ago; level flips once the run of
    // samples differing from it reaches Teff; a run broken early is a glitch.
    bit m_hist[$];
    bit m_level, m_rise, m_fall;
    int m_run, m_glitch;

    always @(posedge clk or posedge rst) begin
        bit s_cur, prev, gl;
        int teff;
        if (rst) begin
            m_hist = {};
            for (int i = 0; i < STAGES; i++) m_hist.push_back(1'b0);
            m_level = 0; m_rise = 0; m_fall = 0; m_run = 0; m_glitch = 0;
        end else begin
            s_cur = m_hist[0];
            prev  = m_level;
            gl    = 0;
            teff  = (thresh == 0) ? 1 : int'(thresh);
            if (!en) begin
                m_level = s_cur;
                m_run   = 0;
            end else if (s_cur != m_level) begin
                m_run++;
                if (m_run >= teff) begin
                    m_level = !m_level;
                    m_run   = 0;
                end
            end else begin
                if (m_run > 0) gl = 1;
                m_run = 0;
            end
            if (clr)     m_glitch = 0;
            else if (gl) m_glitch++;
            m_rise = m_level & !prev;
            m_fall = !m_level & prev;
            void'(m_hist.pop_front());
            m_hist.push_back(serial);
        end
    end

    typedef struct {
        logic       serial;
        logic       en;
        logic [7:0] thresh;
        logic       clr;
        logic       lvl;
        logic       rise;
        logic       fall;
        logic [7:0] gcnt;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] pk(input logic l, input logic r, input logic f, input logic [7:0] g);
        return {21'd0, l, r, f, g};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic sv, input logic ev, input logic [7:0] th, input logic cv,
                       input logic l, input logic r, input logic f, input logic [7:0] g);
        vec_t v;
        v.serial = sv; v.en = ev; v.thresh = th; v.clr = cv;
        v.lvl = l; v.rise = r; v.fall = f; v.gcnt = g;
        tbl.push_back(v);
    endtask

    task automatic step(input logic sv, input logic ev, input logic [7:0] th, input logic cv);
        serial = sv; en = ev; thresh = th; clr = cv;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // clean rise, clean fall, 3-sample glitch, threshold 0 and 1
        for (int i = 0; i < 7; i++) add(1, 1, 8'd4, 0, i >= 5, i == 5, 0, 8'd0);
        for (int i = 0; i < 7; i++) add(0, 1, 8'd4, 0, i < 5, 0, i == 5, 8'd0);
        for (int i = 0; i < 7; i++) add(i < 3, 1, 8'd4, 0, 0, 0, 0, (i >= 5) ? 8'd1 : 8'd0);
        for (int i = 0; i < 4; i++) add(1, 1, 8'd0, 0, i >= 2, i == 2, 0, 8'd1);
        for (int i = 0; i < 4; i++) add(0, 1, 8'd1, 0, i < 2, 0, i == 2, 8'd1);

        #2;
        chk("reset_state", pk(level, rise, fall, g8), pk(0, 0, 0, 8'd0));
        chk("reset_g2", {30'd0, g2}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].serial, tbl[i].en, tbl[i].thresh, tbl[i].clr);
            chk($sformatf("table_row%0d", i), pk(level, rise, fall, g8),
                pk(tbl[i].lvl, tbl[i].rise, tbl[i].fall, tbl[i].gcnt));
        end

        // five glitches: wide counter counts, 2-bit counter saturates
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 6; i++) step(i < 2, 1, 8'd4, 0);
        chk("glitch_sat_g8", {24'd0, g8}, 32'd6);
        chk("glitch_sat_g2", {30'd0, g2}, 32'd3);
        // clear on the very edge a glitch is detected
        for (int i = 0; i < 6; i++) begin
            step(i < 2, 1, 8'd4, i == 4);
            if (i == 4) begin
                chk("clr_vs_glitch_g8", {24'd0, g8}, 32'd0);
                chk("clr_vs_glitch_g2", {30'd0, g2}, 32'd0);
            end
        end

        // reset while a 1->0 transition is pending with two samples counted
        for (int i = 0; i < 4; i++) step(1, 1, 8'd1, 0);
        for (int i = 0; i < 6; i++) step(i >= 2, 1, 8'd4, 0);
        chk("pre_reset", pk(level, rise, fall, g8), pk(1, 0, 0, 8'd1));
        for (int i = 0; i < 4; i++) step(0, 1, 8'd4, 0);
        chk("pending_hold", pk(level, rise, fall, g8), pk(1, 0, 0, 8'd1));
        rst = 1'b1;
        #1;
        chk("async_reset", pk(level, rise, fall, g8), pk(0, 0, 0, 8'd0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 8'd4, 0);
            chk($sformatf("post_reset%0d", i), pk(level, rise, fall, g8), pk(0, 0, 0, 8'd0));
        end

        // bypass: one-cycle pulse passes straight through, glitch count untouched
        for (int i = 0; i < 6; i++) step(i < 2, 1, 8'd4, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8'd4, 0);
        for (int i = 0; i < 6; i++) begin
            step(i == 0, 0, 8'd4, 0);
            chk($sformatf("bypass%0d", i), pk(level, rise, fall, g8),
                pk(i == 2, i == 2, i == 3, 8'd1));
        end

        // maximum threshold: 255 samples needed
        for (int i = 0; i < 256; i++) step(1, 1, 8'hFF, 0);
        chk("thresh_ff_before", pk(level, rise, fall, 8'd0), pk(0, 0, 0, 8'd0));
        step(1, 1, 8'hFF, 0);
        chk("thresh_ff_toggle", pk(level, rise, fall, 8'd0), pk(1, 1, 0, 8'd0));

        // random runs against the reference model
        begin
            int   run_left = 0;
            logic sv = 1'b1;
            logic [7:0] th = 8'd3;
            for (int c = 0; c < 3000; c++) begin
                logic [7:0] e8;
                logic [1:0] e2;
                if (run_left == 0) begin
                    sv = ~sv;
                    run_left = int'($urandom_range(1, 9));
                end
                run_left--;
                if ($urandom_range(0, 39) == 0) th = 8'($urandom_range(0, 6));
                step(sv, $urandom_range(0, 24) != 0, th, $urandom_range(0, 59) == 0);
                e8 = (m_glitch > 255) ? 8'hFF : 8'(m_glitch);
                e2 = (m_glitch > 3) ? 2'd3 : 2'(m_glitch);
                chk("rand_w8", pk(level, rise, fall, g8), pk(m_level, m_rise, m_fall, e8));
                chk("rand_w2", pk(l2, r2, f2, {6'd0, g2}), pk(m_level, m_rise, m_fall, {6'd0, e2}));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
